// File: rtl/xor_seq_pkg.sv
// rtl/xor_seq_pkg.sv - shared types, constants and helpers for the XOR vector sequencer
package xor_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } seq_state_t;

    localparam int         NUM_VECTORS = 16;
    localparam logic [3:0] LAST_INDEX  = 4'd15;

    // Reflected binary Gray code of a 4-bit index
    function automatic logic [3:0] bin2gray(input logic [3:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/xor_seq_settle_timer.sv
// rtl/xor_seq_settle_timer.sv - settle-time down-counter with load and expire
module xor_seq_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic run,
    output logic expired
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYCLES - 1);

    logic [3:0] count;

    // Load SETTLE_CYCLES-1 on entry to a vector, then count down while settling
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (run && count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    // Expired on the last settle cycle of the current vector
    assign expired = (count == 4'd0);

endmodule

// File: rtl/xor_vector_sequencer.sv
// rtl/xor_vector_sequencer.sv - exhaustive 4-input XOR checker; XOR_SEQ_GRAY_ORDER_EN selects Gray vector order
module xor_vector_sequencer
    import xor_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    input  logic             e,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       first_err_vec,
    output logic             first_err_valid
);

    if (ERR_W < 5) begin : g_bad_err_w
        $error("ERR_W must be at least 5 to hold a count of 16");
    end

    seq_state_t state;
    logic [3:0] vec;
    logic [3:0] drive_vec;
    logic       timer_load;
    logic       timer_expired;
    logic       mismatch;

`ifdef XOR_SEQ_GRAY_ORDER_EN
    assign drive_vec = bin2gray(vec);
`else
    assign drive_vec = vec;
`endif

    // Reload the settle timer whenever a new vector begins
    assign timer_load = ((state == IDLE || state == DONE) && start)
                      || (state == SAMPLE && vec != LAST_INDEX);

    // Gate output compared against parity of what is actually being driven
    assign mismatch = (e != (a ^ b ^ c ^ d));

    xor_seq_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load),
        .run    (state == SETTLE),
        .expired(timer_expired)
    );

    // Sweep FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            vec             <= '0;
            {a, b, c, d}    <= 4'b0000;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec             <= '0;
                        err_count       <= '0;
                        first_err_vec   <= '0;
                        first_err_valid <= 1'b0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        state           <= SETTLE;
                    end
                end
                SETTLE: begin
                    {a, b, c, d} <= drive_vec;
                    busy         <= 1'b1;
                    if (timer_expired) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_count <= err_count + ERR_W'(1);
                        if (!first_err_valid) begin
                            first_err_vec   <= {a, b, c, d};
                            first_err_valid <= 1'b1;
                        end
                    end
                    if (vec == LAST_INDEX) begin
                        state <= DONE;
                    end else begin
                        vec   <= vec + 4'd1;
                        state <= SETTLE;
                    end
                end
                DONE: begin
                    {a, b, c, d} <= 4'b0000;
                    if (start) begin
                        vec             <= '0;
                        err_count       <= '0;
                        first_err_vec   <= '0;
                        first_err_valid <= 1'b0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        state           <= SETTLE;
                    end else begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (err_count == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_vector_sequencer.sv
// tb/tb_xor_vector_sequencer.sv - scoreboard bench for xor_vector_sequencer
module tb_xor_vector_sequencer;
    import xor_seq_pkg::*;

    localparam int SC = 2;

    localparam logic [3:0] GRAY_TBL [16] = '{
        4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
        4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8
    };

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       a, b, c, d, e;
    logic       busy, done, pass;
    logic [4:0] err_count;
    logic [3:0] first_err_vec;
    logic       first_err_valid;

    int gate_mode = 0;
    int n_checks  = 0;
    int n_errors  = 0;

    logic [3:0] exp_q [$];

    xor_vector_sequencer #(
        .SETTLE_CYCLES(SC),
        .ERR_W        (5)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .a              (a),
        .b              (b),
        .c              (c),
        .d              (d),
        .e              (e),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_vec  (first_err_vec),
        .first_err_valid(first_err_valid)
    );

    always #5 clk = ~clk;

    assign e = (gate_mode == 0) ? (a ^ b ^ c ^ d)
             : (gate_mode == 1) ? 1'b0
             : ~(a ^ b ^ c ^ d);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] order_vec(input int j);
`ifdef XOR_SEQ_GRAY_ORDER_EN
        return GRAY_TBL[j];
`else
        return 4'(j);
`endif
    endfunction

    function automatic logic gate_model(input int mode, input logic [3:0] v);
        if (mode == 0) return ^v;
        if (mode == 1) return 1'b0;
        return ~(^v);
    endfunction

    // Full sweep from start to done; start pulses injected at edges ga/gb
    task automatic run_sweep(input int mode, input int ga, input int gb, input string name);
        int         exp_errs;
        int         edge_n;
        logic [3:0] exp_first;
        logic       exp_first_valid;
        logic [3:0] v;
        logic [3:0] obs;
        logic [3:0] prev_obs;
        exp_errs        = 0;
        exp_first       = 4'd0;
        exp_first_valid = 1'b0;
        prev_obs        = 4'd0;
        gate_mode       = mode;
        for (int j = 0; j < NUM_VECTORS; j++) begin
            v = order_vec(j);
            exp_q.push_back(v);
            if (gate_model(mode, v) != ^v) begin
                exp_errs++;
                if (!exp_first_valid) begin
                    exp_first       = v;
                    exp_first_valid = 1'b1;
                end
            end
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        edge_n = 0;
        check({name, ".busy_start"}, busy, 1);
        check({name, ".done_drop"}, done, 0);
        for (int j = 0; j < NUM_VECTORS; j++) begin
            v = exp_q.pop_front();
            for (int k = 0; k < SC + 1; k++) begin
                @(posedge clk);
                #1;
                edge_n++;
                obs = {a, b, c, d};
                check($sformatf("%s.vec%0d_%0d", name, j, k), obs, v);
`ifdef XOR_SEQ_GRAY_ORDER_EN
                if (k == 0 && j > 0)
                    check($sformatf("%s.hamming%0d", name, j), $countones(obs ^ prev_obs), 1);
`endif
                if (k == 0) prev_obs = obs;
                start = (edge_n + 1 == ga) || (edge_n + 1 == gb);
            end
        end
        start = 1'b0;
        check({name, ".done_early"}, done, 0);
        check({name, ".last_vec"}, prev_obs, order_vec(NUM_VECTORS - 1));
        @(posedge clk);
        #1;
        check({name, ".done"}, done, 1);
        check({name, ".busy_end"}, busy, 0);
        check({name, ".pass"}, pass, (exp_errs == 0));
        check({name, ".err_count"}, err_count, exp_errs);
        check({name, ".first_valid"}, first_err_valid, exp_first_valid);
        check({name, ".first_vec"}, first_err_vec, exp_first);
        check({name, ".abcd_idle"}, {a, b, c, d}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         exp_partial;
        logic [3:0] v;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.abcd", {a, b, c, d}, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.pass", pass, 0);
        check("rst.err_count", err_count, 0);
        check("rst.first_vec", first_err_vec, 0);
        check("rst.first_valid", first_err_valid, 0);
        @(negedge clk);
        reset = 1'b0;

        run_sweep(0, -1, -1, "good");
        run_sweep(1, -1, -1, "stuck0");
        run_sweep(2, -1, -1, "xnor");
        run_sweep(0, 10, 20, "glitch");

        // Reset while vector 5 is settling
        gate_mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3 * 5 + 1) @(posedge clk);
        #1;
        exp_partial = 0;
        for (int j = 0; j < 5; j++) begin
            v = order_vec(j);
            if (^v) exp_partial++;
        end
        check("mid.vec5", {a, b, c, d}, order_vec(5));
        check("mid.err_count", err_count, exp_partial);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst.abcd", {a, b, c, d}, 0);
        check("mid_rst.busy", busy, 0);
        check("mid_rst.err_count", err_count, 0);
        check("mid_rst.first_valid", first_err_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        run_sweep(0, -1, -1, "after_rst");

        // Reset and start together: reset wins
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("rst_start.busy", busy, 0);
        check("rst_start.done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("rst_start.idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
